// File: rtl/kiu_pkg.sv
// Shared types and constants for the multi-source interrupt unit.
// Holds the request/ack FSM encoding and the arbitration and latching mode selectors.
package kiu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } kiu_state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  localparam logic EDGE  = 1'b1;
  localparam logic LEVEL = 1'b0;

  // Advance a source index by one with wrap-around at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/kiu_priority_arbiter.sv
// Combinational priority search over the pending vector.
// Fixed mode always starts at index 0; round-robin mode starts at start_ptr and wraps.
module kiu_priority_arbiter
  import kiu_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] pend,
  input  logic [ID_W-1:0]    start_ptr,
  input  logic               rr_mode,
  output logic               found,
  output logic [ID_W-1:0]    winner
);

  int            base;
  int            idx;
  logic [ID_W-1:0] idx_w;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    base   = rr_mode ? int'(start_ptr) : 0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = base + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = ID_W'(idx);
      if (!found && pend[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

// File: rtl/multi_source_interrupt_unit.sv
// Multi-source interrupt unit: per-source synchroniser, edge/level latching, masking,
// arbitration and a REQ/ACK handshake towards the branch/exception unit.
module multi_source_interrupt_unit
  import kiu_pkg::*;
#(
  parameter int               NUM_SRC     = 8,
  parameter int               ID_W        = $clog2(NUM_SRC),
  parameter int               SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MODE = {NUM_SRC{1'b1}},
  parameter int               PRIO_MODE   = 0
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_Req,
  input  logic [NUM_SRC-1:0] Cfg_Mask,
  input  logic               S_Mode_IF,
  input  logic               Core_IntTaken,
  output logic               KIU_IntReq,
  output logic [ID_W-1:0]    KIU_IntId,
  output logic [NUM_SRC-1:0] Src_Ack,
  output logic [NUM_SRC-1:0] Pend
);

  logic [NUM_SRC-1:0] s_sync;
  logic [NUM_SRC-1:0] s_prev_q, s_prev_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] pend_out_q, pend_out_d;
  logic [NUM_SRC-1:0] src_ack_q, src_ack_d;

  kiu_state_t         state_q, state_d;
  logic               req_q, req_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic               arb_found;
  logic [ID_W-1:0]    arb_winner;

  // Synchronisers: one shift chain per source, s is the last stage.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], Src_Req[i]};
    end

    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
      if (!Sys_Reset) sync_q <= '0;
      else            sync_q <= sync_d;
    end

    assign s_sync[i] = sync_q[SYNC_STAGES-1];
  end

  // Edge sources latch and hold until acknowledged (set beats clear); level sources follow s.
  always_comb begin
    s_prev_d   = s_sync;
    pend_d     = (EDGE_MODE & ((s_sync & ~s_prev_q) | (pend_q & ~src_ack_q)))
               | (~EDGE_MODE & s_sync);
    pend_out_d = pend_d & Cfg_Mask;
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      s_prev_q   <= '0;
      pend_q     <= '0;
      pend_out_q <= '0;
    end else begin
      s_prev_q   <= s_prev_d;
      pend_q     <= pend_d;
      pend_out_q <= pend_out_d;
    end
  end

  kiu_priority_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .pend      (pend_out_q),
    .start_ptr (rr_ptr_q),
    .rr_mode   (PRIO_MODE == PRIO_RR),
    .found     (arb_found),
    .winner    (arb_winner)
  );

  // The ID is frozen in REQ; a take beats a simultaneous withdrawal.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    src_ack_d = '0;
    case (state_q)
      IDLE: begin
        if (arb_found && !S_Mode_IF) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = arb_winner;
        end
      end
      REQ: begin
        if (Core_IntTaken) begin
          state_d   = ACK;
          req_d     = 1'b0;
          src_ack_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_q;
          rr_ptr_d  = ID_W'(wrap_inc(int'(id_q), NUM_SRC));
        end else if (!pend_out_q[id_q] || S_Mode_IF) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      src_ack_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      src_ack_q <= src_ack_d;
    end
  end

  assign KIU_IntReq = req_q;
  assign KIU_IntId  = id_q;
  assign Src_Ack    = src_ack_q;
  assign Pend       = pend_out_q;

endmodule
